// File: rtl/arith_sequencer.sv
// arith_sequencer
//   Accepts one arithmetic request at a time and sequences it to completion.
//   Add/sub are evaluated locally; mul/div are handed to external units via a
//   one-cycle start pulse and completed when the unit's halt level rises
//   (after having been seen low at least once), or aborted after TIMEOUT
//   wait cycles.
//
// Ports
//   Clock       rising-edge clock for all state
//   Reset       asynchronous active-high reset
//   Req         operation request, sampled only while idle
//   Op          00 add, 01 sub, 10 mul, 11 div
//   A, B        unsigned 8-bit operands
//   MulStart    one-cycle start pulse to the multiplier
//   MulHalt     multiplier halted/complete level
//   MulProduct  multiplier result
//   DivStart    one-cycle start pulse to the divider
//   DivHalt     divider halted/complete level
//   DivQuot     divider quotient
//   DivRem      divider remainder
//   Busy        high from the cycle after acceptance through the Done cycle
//   Done        one-cycle completion pulse
//   Result      operation result, held until the next completion
//   Err         error flag, valid with Done and held with Result
module arith_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [1:0]  Op,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        MulStart,
    input  logic        MulHalt,
    input  logic [15:0] MulProduct,
    output logic        DivStart,
    input  logic        DivHalt,
    input  logic [7:0]  DivQuot,
    input  logic [7:0]  DivRem,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Result,
    output logic        Err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        EXEC  = 5'b00010,
        ISSUE = 5'b00100,
        WAIT  = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [CW-1:0]   cnt;
    logic            armed;

    logic            halt;
    logic [15:0]     sum;
    logic [15:0]     diff;
    logic [15:0]     unit_result;

    always_comb begin
        halt        = (op_q == OP_MUL) ? MulHalt : DivHalt;
        unit_result = (op_q == OP_MUL) ? MulProduct : {DivRem, DivQuot};
        // Zero-extended operands: the add keeps its carry in bit 8, the
        // subtract wraps to a 16-bit two's-complement value.
        sum         = {8'h00, a_q} + {8'h00, b_q};
        diff        = {8'h00, a_q} - {8'h00, b_q};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            MulStart <= 1'b0;
            DivStart <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            Err      <= 1'b0;
        end else begin
            MulStart <= 1'b0;
            DivStart <= 1'b0;
            Done     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (Req) begin
                        op_q <= op_t'(Op);
                        a_q  <= A;
                        b_q  <= B;
                        Busy <= 1'b1;
                        if (op_t'(Op) == OP_DIV && B == 8'h00) begin
                            // Divide by zero never reaches the divider.
                            state  <= DONE;
                            Done   <= 1'b1;
                            Result <= '1;
                            Err    <= 1'b1;
                        end else if (Op[1]) begin
                            // Start pulses are registered so they line up
                            // exactly with the ISSUE cycle.
                            state    <= ISSUE;
                            MulStart <= ~Op[0];
                            DivStart <= Op[0];
                        end else begin
                            state <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    Result <= (op_q == OP_SUB) ? diff : sum;
                    Err    <= 1'b0;
                    Done   <= 1'b1;
                    state  <= DONE;
                end

                ISSUE: begin
                    cnt   <= '0;
                    armed <= 1'b0;
                    state <= WAIT;
                end

                WAIT: begin
                    // Armed completion takes priority over the timeout.
                    if (armed && halt) begin
                        Result <= unit_result;
                        Err    <= 1'b0;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        Result <= '0;
                        Err    <= 1'b1;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (!halt) begin
                            armed <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_sequencer.sv
module tb_arith_sequencer;

    localparam int unsigned TO = 63;
    localparam int unsigned NEVER = 1000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req;
    logic [1:0]  Op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        MulStart;
    logic        MulHalt;
    logic [15:0] MulProduct;
    logic        DivStart;
    logic        DivHalt;
    logic [7:0]  DivQuot;
    logic [7:0]  DivRem;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        Err;

    arith_sequencer #(.TIMEOUT(TO)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .MulStart   (MulStart),
        .MulHalt    (MulHalt),
        .MulProduct (MulProduct),
        .DivStart   (DivStart),
        .DivHalt    (DivHalt),
        .DivQuot    (DivQuot),
        .DivRem     (DivRem),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .Err        (Err)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] result;
        logic        err;
        int unsigned lat;
        int unsigned acc;
        int unsigned mul_p;
        int unsigned div_p;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Plan for the external unit serving the current transaction.
    int unsigned p_kind = 0;   // 0 none, 1 mul, 2 div
    logic        p_init = 1'b1;
    int unsigned p_drop = 1;
    int unsigned p_rise = NEVER;
    logic [15:0] p_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Halt level the unit shows in WAIT cycle j (1-based).
    function automatic logic halt_plan(input logic init, input int unsigned drop,
                                       input int unsigned rise, input int unsigned j);
        if (j < drop) return init;
        if (j < rise) return 1'b0;
        return 1'b1;
    endfunction

    // Completion rule: the first high halt after any low one completes;
    // otherwise the operation gives up after TO wait cycles.
    function automatic int unsigned wait_model(input logic init, input int unsigned drop,
                                               input int unsigned rise, output logic to);
        logic seen_low;
        logic h;
        seen_low = 1'b0;
        for (int unsigned j = 1; j <= TO; j++) begin
            h = halt_plan(init, drop, rise, j);
            if (h && seen_low) begin
                to = 1'b0;
                return j;
            end
            if (!h) seen_low = 1'b1;
        end
        to = 1'b1;
        return TO;
    endfunction

    // Waits for idle, randomly pulsing Req while busy (must be ignored).
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge Clock);
            if (!Busy && !Done) begin
                ok = 1'b1;
                break;
            end
            Req = ($urandom_range(0, 3) == 0);
            Op  = 2'($urandom);
            A   = 8'($urandom);
            B   = 8'($urandom);
        end
        Req = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle_wait: got busy expected idle within 400 cycles");
            finish_tb();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic init, input int unsigned drop, input int unsigned rise);
        exp_t        e;
        logic        to;
        int unsigned w;
        wait_idle();
        e.mul_p = 0;
        e.div_p = 0;
        e.err   = 1'b0;
        p_kind  = 0;
        case (op)
            2'b00: begin e.result = 16'(int'(a) + int'(b)); e.lat = 2; end
            2'b01: begin e.result = 16'(int'(a) - int'(b)); e.lat = 2; end
            2'b10: begin
                p_kind = 1;
                p_good = 16'(int'(a) * int'(b));
                w = wait_model(init, drop, rise, to);
                e.result = to ? 16'h0000 : p_good;
                e.err    = to;
                e.lat    = 2 + w;
                e.mul_p  = 1;
            end
            default: begin
                if (b == 8'h00) begin
                    e.result = 16'hFFFF;
                    e.err    = 1'b1;
                    e.lat    = 1;
                end else begin
                    p_kind = 2;
                    p_good = {8'(int'(a) % int'(b)), 8'(int'(a) / int'(b))};
                    w = wait_model(init, drop, rise, to);
                    e.result = to ? 16'h0000 : p_good;
                    e.err    = to;
                    e.lat    = 2 + w;
                    e.div_p  = 1;
                end
            end
        endcase
        p_init = init;
        p_drop = drop;
        p_rise = rise;
        MulHalt    = (p_kind == 1) ? init : 1'b1;
        DivHalt    = (p_kind == 2) ? init : 1'b1;
        MulProduct = ~p_good;
        {DivRem, DivQuot} = ~p_good;
        Op  = op;
        A   = a;
        B   = b;
        Req = 1'b1;
        @(posedge Clock);
        #1;
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge Clock);
        Req = 1'b0;
    endtask

    // External unit model: follows the plan once a start pulse is seen.
    initial begin : unit_model
        int unsigned j_u;
        bit          act;
        logic        h;
        act = 1'b0;
        j_u = 0;
        forever begin
            @(negedge Clock);
            if (MulStart || DivStart) begin
                j_u = 0;
                act = 1'b1;
            end else if (act) begin
                if (!Busy) begin
                    act = 1'b0;
                end else begin
                    j_u++;
                    h = halt_plan(p_init, p_drop, p_rise, j_u);
                    if (p_kind == 1) begin
                        MulHalt    = h;
                        MulProduct = (j_u >= p_rise) ? p_good : ~p_good;
                    end else begin
                        DivHalt           = h;
                        {DivRem, DivQuot} = (j_u >= p_rise) ? p_good : ~p_good;
                    end
                end
            end
        end
    end

    // Monitor: every Done pops one expectation from the scoreboard.
    initial begin : monitor
        int unsigned busy_cnt;
        int unsigned mp;
        int unsigned dp;
        int unsigned both;
        exp_t        e;
        busy_cnt = 0; mp = 0; dp = 0; both = 0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                busy_cnt = 0; mp = 0; dp = 0; both = 0;
            end else begin
                if (Busy)                 busy_cnt++;
                if (MulStart)             mp++;
                if (DivStart)             dp++;
                if (MulStart && DivStart) both++;
                if (Done) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got Done=1 expected no Done (Result=%0h)", Result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result",     32'(Result),            32'(e.result));
                        check("err",        32'(Err),               32'(e.err));
                        check("latency",    cyc - e.acc + 1,        e.lat);
                        check("busy_len",   busy_cnt,               e.lat);
                        check("mul_pulses", mp,                     e.mul_p);
                        check("div_pulses", dp,                     e.div_p);
                        check("start_both", both,                   0);
                    end
                    busy_cnt = 0; mp = 0; dp = 0; both = 0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int unsigned drop;
        int unsigned rise;
        int unsigned r;
        Reset = 1'b1;
        Req = 1'b0; Op = '0; A = '0; B = '0;
        MulHalt = 1'b1; DivHalt = 1'b1;
        MulProduct = '0; DivQuot = '0; DivRem = '0;
        repeat (2) @(negedge Clock);
        check("reset_outputs", 32'({Busy, Done, Err, MulStart, DivStart, Result}), 32'h0);
        Reset = 1'b0;

        // Directed cases.
        issue(2'b00, 8'hF0, 8'h20, 1'b1, 1, NEVER);     // 16'h0110
        issue(2'b01, 8'd3,  8'd5,  1'b1, 1, NEVER);     // 16'hFFFE
        issue(2'b10, 8'h0C, 8'h0A, 1'b1, 1, 21);        // stale high, 16'h0078
        issue(2'b11, 8'h64, 8'h00, 1'b1, 1, NEVER);     // divide by zero
        issue(2'b11, 8'h64, 8'h07, 1'b0, 1, NEVER);     // stuck low -> timeout
        issue(2'b10, 8'hFF, 8'hFF, 1'b1, 1, TO);        // completes on last cycle
        issue(2'b11, 8'hC8, 8'h0D, 1'b1, 1, TO + 1);    // one cycle too late
        issue(2'b11, 8'hC8, 8'h0D, 1'b1, 3, 4);         // long stale high

        // Reset during a multiply wait: immediate clear, no Done.
        issue(2'b10, 8'h12, 8'h34, 1'b1, 1, NEVER);
        repeat (10) @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("reset_mid_wait", 32'({Busy, Done, Err, MulStart, DivStart, Result}), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        issue(2'b00, 8'd1, 8'd1, 1'b1, 1, NEVER);        // 16'h0002

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (op == 2'b11 && $urandom_range(0, 3) == 0) b = 8'h00;
            drop = $urandom_range(1, 4);
            r = $urandom_range(0, 7);
            case (r)
                0:       rise = NEVER;
                1:       rise = TO;
                2:       rise = TO + 1;
                default: rise = drop + 1 + $urandom_range(0, 24);
            endcase
            issue(op, a, b, 1'($urandom), drop, rise);
        end

        wait_idle();
        repeat (2) @(negedge Clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        finish_tb();
    end

endmodule

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum WAIT cycles allowed for an external unit before abort.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req  input  1  operation request, sampled only in IDLE.
REQ-005 Op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-006 A, B  input  8 each  unsigned operands.
REQ-007 MulStart  output  1  start pulse to the shift-add multiplier unit.
REQ-008 MulHalt  input  1  multiplier halted/complete level.
REQ-009 MulProduct  input  16  multiplier result.
REQ-010 DivStart  output  1  start pulse to the divider unit.
REQ-011 DivHalt  input  1  divider halted/complete level.
REQ-012 DivQuot, DivRem  input  8 each  divider results.
REQ-013 Busy  output  1  high from the cycle after acceptance until the DONE cycle, inclusive.
REQ-014 Done  output  1  one-cycle completion pulse.
REQ-015 Result  output  16  operation result, held until the next acceptance.
REQ-016 Err  output  1  error flag, valid with Done and held with Result.

Function
REQ-017 The FSM SHALL use the states IDLE, EXEC, ISSUE, WAIT and DONE, one-hot encoded.
REQ-018 IDLE with Req=1 SHALL latch Op, A and B at that edge and transition by opcode: add/sub -> EXEC; mul -> ISSUE; div with B!=0 -> ISSUE; div with B==0 -> DONE.
REQ-019 Req SHALL be ignored in every state except IDLE; requests SHALL NOT be queued.
REQ-020 EXEC SHALL produce Result as follows, then transition to DONE:
  - add: Result = {7'b0, carry, A+B}.
  - sub: Result = 16-bit two's-complement of zero-extended A-B (e.g. 3-5 = 16'hFFFE).
REQ-021 ISSUE SHALL assert MulStart or DivStart (selected by the latched Op) for exactly one cycle, then transition to WAIT.
REQ-022 In WAIT, the unit's Halt SHALL count as completion only after Halt has been sampled low at least once since ISSUE (arm flag); a stale high Halt SHALL be ignored.
REQ-023 Armed Halt=1 in WAIT SHALL transition to DONE and load Result:
  - mul: MulProduct.
  - div: {DivRem, DivQuot}.
  - Err=0 in both cases.
REQ-024 The WAIT cycle counter SHALL clear in ISSUE and increment each WAIT cycle; reaching TIMEOUT without armed completion SHALL transition to DONE with Result=16'h0000, Err=1.
REQ-025 Div with B==0 SHALL never assert DivStart and SHALL complete with Result=16'hFFFF, Err=1.
REQ-026 DONE SHALL assert Done for one cycle, hold Result/Err, and return to IDLE.
REQ-027 Latency from the accepting edge to Done high SHALL be:
  - add/sub: 2 cycles.
  - div by zero: 1 cycle.
  - mul/div: 2 + WAIT cycles.
REQ-028 Armed completion and TIMEOUT in the same cycle SHALL resolve as completion (Err=0).
REQ-029 MulStart and DivStart SHALL never be high simultaneously and SHALL be low outside ISSUE.
REQ-030 Result and Err SHALL change only on a DONE transition or on reset.

Reset
REQ-031 Reset high SHALL immediately force:
  - state IDLE.
  - Busy=0, Done=0, Err=0, Result=16'h0000.
  - MulStart=0, DivStart=0.
  - counter and arm flag cleared.
REQ-032 Reset asserted mid-operation SHALL abort it with no Done pulse; the first Req after reset release SHALL be accepted normally.

Verification
REQ-033 Add: A=8'hF0, B=8'h20, Op=00 -> Done 2 cycles later, Result=16'h0110, Err=0.
REQ-034 Sub: A=3, B=5, Op=01 -> Result=16'hFFFE, Err=0; Busy high 2 cycles.
REQ-035 Mul: A=8'h0C, B=8'h0A, MulHalt held high before the request, model drops Halt 1 cycle after MulStart and raises it 20 cycles later with 16'h0078 -> exactly one MulStart pulse, no early completion, Result=16'h0078.
REQ-036 Div: A=8'h64, B=0 -> DivStart never asserted, Done 1 cycle after acceptance, Result=16'hFFFF, Err=1.
REQ-037 Div timeout: TIMEOUT=63, DivHalt stuck low -> Done after 63 WAIT cycles, Result=0, Err=1; a Req pulsed during WAIT is ignored.
REQ-038 Reset mid-WAIT: assert Reset during a mul -> all outputs 0 immediately, no Done; a subsequent add of 1+1 -> Result=16'h0002.
